dram_cmd_ctrl: RTL and testbench

- Controller-side counterpart of the DDR3 PHY: runs in the PHY's `divclk` domain and generates the per-cycle DRAM command stream that the PHY serialises to the pins.
- Performs the JEDEC power-up/init sequence, periodic refresh, and single-request closed-page access: ACT, then RD/WR with auto-precharge, then a recovery wait.
- Upstream masters issue one burst-8 request at a time via a valid/ready handshake.
- Command encoding in this spec lists the signals in the order {cs_n, ras_n, cas_n, we_n}.

---
 rtl/dram_cmd_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dram_cmd_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_ctrl.sv
// dram_cmd_ctrl: DDR3 init, periodic refresh and closed-page single-request command sequencer
module dram_cmd_ctrl #(
  parameter int W = 2,
  parameter int ROW_W = 16,
  parameter int COL_W = 10,
  parameter int T_RST = 50000,
  parameter int T_CKE = 125000,
  parameter int T_XPR = 64,
  parameter int T_MRD = 4,
  parameter int T_ZQINIT = 128,
  parameter int T_RCD = 3,
  parameter int T_RDA = 8,
  parameter int T_WRA = 12,
  parameter int T_RFC = 40,
  parameter int T_REFI = 1950,
  parameter logic [15:0] MR0 = 16'h0,
  parameter logic [15:0] MR1 = 16'h0,
  parameter logic [15:0] MR2 = 16'h0,
  parameter logic [15:0] MR3 = 16'h0
) (
  input  logic divclk,
  input  logic reset,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_write,
  input  logic [2+ROW_W+COL_W:0] req_addr,
  output logic init_done,
  output logic reset_n,
  output logic cke,
  output logic cs_n,
  output logic ras_n,
  output logic cas_n,
  output logic we_n,
  output logic [2:0] ba,
  output logic [15:0] addr,
  output logic odt,
  output logic wr_en,
  output logic rd_en
);
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] REF = 4'b0001, MRS = 4'b0000, ZQCL = 4'b0110;
  typedef enum logic [3:0] {
    S_RST_LOW, S_CKE_WAIT, S_XPR, S_MRS2, S_MRS3, S_MRS1, S_MRS0, S_ZQ, S_IDLE, S_RCD, S_REC, S_RFC
  } state_t;
  state_t state;
  logic [3:0] cmd;
  logic [31:0] cnt, refcnt;
  logic [2:0] odt_cnt, bank_q;
  logic [COL_W-1:0] col_q;
  logic pending, wr_q, ref_exp;
  assign {cs_n, ras_n, cas_n, we_n} = cmd;
  assign ref_exp = init_done && refcnt == 32'(T_REFI - 1);
  assign req_ready = state == S_IDLE && init_done && !pending;
  // Each state is the wait that follows the command issued on entry; cnt holds the remaining cycles.
  always_ff @(posedge divclk) begin
    if (reset) begin
      state <= S_RST_LOW;
      cnt <= 32'(T_RST - 1);
      reset_n <= 1'b0;
      cke <= 1'b0;
      cmd <= NOP;
      ba <= '0;
      addr <= '0;
      odt <= 1'b0;
      odt_cnt <= '0;
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      init_done <= 1'b0;
      refcnt <= '0;
      pending <= 1'b0;
      wr_q <= 1'b0;
      bank_q <= '0;
      col_q <= '0;
    end else begin
      cmd <= NOP;
      ba <= '0;
      addr <= '0;
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      cnt <= cnt != 0 ? cnt - 1 : cnt;
      refcnt <= ref_exp ? '0 : init_done ? refcnt + 1 : refcnt;
      pending <= ref_exp || (pending && state != S_IDLE);
      odt_cnt <= odt_cnt != 0 ? odt_cnt - 1 : odt_cnt;
      odt <= odt_cnt != 0;
      case (state)
        S_RST_LOW: if (cnt == 0) begin
          reset_n <= 1'b1;
          cnt <= 32'(T_CKE - 1);
          state <= S_CKE_WAIT;
        end
        S_CKE_WAIT: if (cnt == 0) begin
          cke <= 1'b1;
          cnt <= 32'(T_XPR - 1);
          state <= S_XPR;
        end
        S_XPR: if (cnt == 0) begin
          cmd <= MRS;
          ba <= 3'd2;
          addr <= MR2;
          cnt <= 32'(T_MRD - 1);
          state <= S_MRS2;
        end
        S_MRS2: if (cnt == 0) begin
          cmd <= MRS;
          ba <= 3'd3;
          addr <= MR3;
          cnt <= 32'(T_MRD - 1);
          state <= S_MRS3;
        end
        S_MRS3: if (cnt == 0) begin
          cmd <= MRS;
          ba <= 3'd1;
          addr <= MR1;
          cnt <= 32'(T_MRD - 1);
          state <= S_MRS1;
        end
        S_MRS1: if (cnt == 0) begin
          cmd <= MRS;
          ba <= 3'd0;
          addr <= MR0;
          cnt <= 32'(T_MRD - 1);
          state <= S_MRS0;
        end
        S_MRS0: if (cnt == 0) begin
          cmd <= ZQCL;
          addr <= 16'h0400;
          cnt <= 32'(T_ZQINIT - 1);
          state <= S_ZQ;
        end
        S_ZQ: if (cnt == 0) begin
          init_done <= 1'b1;
          state <= S_IDLE;
        end
        S_IDLE: if (pending) begin
          cmd <= REF;
          cnt <= 32'(T_RFC - 1);
          state <= S_RFC;
        end else if (req_valid && init_done) begin
          cmd <= ACT;
          ba <= req_addr[2+ROW_W+COL_W -: 3];
          addr <= 16'(req_addr[ROW_W+COL_W-1 -: ROW_W]);
          wr_q <= req_write;
          bank_q <= req_addr[2+ROW_W+COL_W -: 3];
          col_q <= req_addr[COL_W-1:0];
          cnt <= 32'(T_RCD - 1);
          state <= S_RCD;
        end
        // Column command with auto-precharge (A10) and fixed BL8 (A12).
        S_RCD: if (cnt == 0) begin
          cmd <= wr_q ? WR : RD;
          ba <= bank_q;
          addr <= 16'(col_q) | 16'h1400;
          wr_en <= wr_q;
          rd_en <= !wr_q;
          odt <= wr_q ? 1'b1 : odt_cnt != 0;
          odt_cnt <= wr_q ? 3'd5 : odt_cnt;
          cnt <= wr_q ? 32'(T_WRA - 1) : 32'(T_RDA - 1);
          state <= S_REC;
        end
        default: if (cnt == 0) state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_cmd_ctrl.sv
// tb_dram_cmd_ctrl: directed checks of init, read/write access, refresh priority and mid-access reset
module tb_dram_cmd_ctrl;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] REF = 4'b0001, MRS = 4'b0000, ZQCL = 4'b0110;
  localparam logic [15:0] MR0 = 16'h1D70, MR1 = 16'h0044, MR2 = 16'h0008, MR3 = 16'h0004;
  logic divclk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_write = 1'b0;
  logic [28:0] req_addr = {3'd5, 16'h1234, 10'h3A};
  logic req_ready, init_done, reset_n, cke, cs_n, ras_n, cas_n, we_n, odt, wr_en, rd_en;
  logic [2:0] ba;
  logic [15:0] addr;
  logic [3:0] cmd;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  assign cmd = {cs_n, ras_n, cas_n, we_n};

  dram_cmd_ctrl #(
    .T_RST(4), .T_CKE(6), .T_XPR(3), .T_MRD(2), .T_ZQINIT(5), .T_RFC(4), .T_REFI(20),
    .MR0(MR0), .MR1(MR1), .MR2(MR2), .MR3(MR3)
  ) dut (
    .divclk(divclk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .init_done(init_done), .reset_n(reset_n),
    .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr),
    .odt(odt), .wr_en(wr_en), .rd_en(rd_en)
  );

  always #5 divclk = ~divclk;
  always @(posedge divclk) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge divclk);
  endtask

  // Observes cycles 0..26 after reset release and checks every init milestone.
  task automatic run_init();
    int t_rn = -1, t_cke = -1, t_done = -1, t_zq = -1, n_cmd = 0, n_mrs = 0;
    logic [15:0] zq_addr = '0;
    int mrs_t[4] = '{default: -1};
    logic [2:0] mrs_ba[4] = '{default: '0};
    logic [15:0] mrs_a[4] = '{default: '0};
    int exp_ba[4] = '{2, 3, 1, 0};
    logic [15:0] exp_a[4] = '{MR2, MR3, MR1, MR0};
    forever begin
      if (reset_n === 1'b1 && t_rn < 0) t_rn = cyc;
      if (cke === 1'b1 && t_cke < 0) t_cke = cyc;
      if (init_done === 1'b1 && t_done < 0) t_done = cyc;
      if (cmd !== NOP) n_cmd++;
      if (cmd === MRS && n_mrs < 4) begin
        mrs_t[n_mrs] = cyc;
        mrs_ba[n_mrs] = ba;
        mrs_a[n_mrs] = addr;
        n_mrs++;
      end
      if (cmd === ZQCL) begin
        t_zq = cyc;
        zq_addr = addr;
      end
      if (cyc >= 26) break;
      @(negedge divclk);
    end
    check("init_reset_n_rise", t_rn, 4);
    check("init_cke_rise", t_cke, 10);
    check("init_mrs_count", n_mrs, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("init_mrs%0d_cyc", i), mrs_t[i], 13 + 2 * i);
      check($sformatf("init_mrs%0d_ba", i), mrs_ba[i], exp_ba[i]);
      check($sformatf("init_mrs%0d_addr", i), mrs_a[i], exp_a[i]);
    end
    check("init_zqcl_cyc", t_zq, 21);
    check("init_zqcl_addr", zq_addr, 16'h0400);
    check("init_cmd_count", n_cmd, 5);
    check("init_done_rise", t_done, 26);
  endtask

  initial begin
    int ev_t[$];
    logic [3:0] ev_c[$];
    int n_acc = 0, n_act = 0;
    int exp_t[10] = '{55, 60, 63, 72, 77, 80, 89, 94, 97, 106};
    logic [3:0] exp_c[10] = '{REF, ACT, RD, REF, ACT, RD, REF, ACT, RD, ACT};
    repeat (3) @(negedge divclk);
    check("rst_cmd", cmd, NOP);
    check("rst_reset_n", reset_n, 0);
    check("rst_cke", cke, 0);
    check("rst_ready", req_ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_ba_addr", {ba, addr}, 0);
    check("rst_odt_en", {odt, wr_en, rd_en}, 0);
    reset = 1'b0;
    run_init();
    check("rd_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_write = 1'b0;
    to_cyc(27);
    check("rd_act_cmd", cmd, ACT);
    check("rd_act_ba", ba, 5);
    check("rd_act_addr", addr, 16'h1234);
    check("rd_ready_busy", req_ready, 0);
    req_valid = 1'b0;
    to_cyc(28);
    check("rd_rcd_nop1", cmd, NOP);
    to_cyc(29);
    check("rd_rcd_nop2", cmd, NOP);
    to_cyc(30);
    check("rd_cmd", cmd, RD);
    check("rd_ba", ba, 5);
    check("rd_addr", addr, 16'h143A);
    check("rd_strobes", {rd_en, wr_en, odt}, 3'b100);
    to_cyc(31);
    check("rd_after", {cmd, rd_en}, {NOP, 1'b0});
    to_cyc(37);
    check("rd_rec_ready", req_ready, 0);
    to_cyc(38);
    check("rd_done_ready", req_ready, 1);
    req_valid = 1'b1;
    req_write = 1'b1;
    to_cyc(39);
    check("wr_act_cmd", cmd, ACT);
    check("wr_act_addr", addr, 16'h1234);
    req_valid = 1'b0;
    to_cyc(41);
    check("wr_pre_odt", {cmd, odt}, {NOP, 1'b0});
    to_cyc(42);
    check("wr_cmd", cmd, WR);
    check("wr_ba", ba, 5);
    check("wr_addr", addr, 16'h143A);
    check("wr_strobes", {wr_en, rd_en, odt}, 3'b101);
    to_cyc(43);
    check("wr_en_single", {cmd, wr_en, odt}, {NOP, 2'b01});
    to_cyc(47);
    check("wr_odt_last", odt, 1);
    to_cyc(48);
    check("wr_odt_off", odt, 0);
    to_cyc(53);
    check("wr_rec_ready", req_ready, 0);
    req_valid = 1'b1;
    req_write = 1'b0;
    to_cyc(54);
    check("ref_blocks_ready", req_ready, 0);
    forever begin
      if (cmd !== NOP) begin
        ev_t.push_back(cyc);
        ev_c.push_back(cmd);
      end
      if (req_valid && req_ready) n_acc++;
      if (cmd === ACT) n_act++;
      if (cyc >= 107) break;
      @(negedge divclk);
    end
    check("ref_event_count", ev_t.size(), 10);
    for (int i = 0; i < 10 && i < ev_t.size(); i++) begin
      check($sformatf("ref_ev%0d_cyc", i), ev_t[i], exp_t[i]);
      check($sformatf("ref_ev%0d_cmd", i), ev_c[i], exp_c[i]);
    end
    check("b2b_accepts", n_acc, 4);
    check("b2b_act_per_accept", n_act, n_acc);
    reset = 1'b1;
    @(negedge divclk);
    check("midrst_cmd", cmd, NOP);
    check("midrst_pins", {reset_n, cke}, 0);
    check("midrst_done_ready", {init_done, req_ready}, 0);
    check("midrst_cyc", cyc, 0);
    reset = 1'b0;
    req_valid = 1'b0;
    run_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
